// File: rtl/program_counter_if.sv
// Bus bundle for program_counter: data-in, strobes, output enables and gated PC outputs.
interface program_counter_if;
  localparam int unsigned PC_W = 12;

  logic [PC_W-1:0] in;
  logic            ld;
  logic            inc;
  logic            skip;
  logic            oe1;
  logic            oe2;
  logic [PC_W-1:0] out1;
  logic [PC_W-1:0] out2;
  logic            skipPending;

  modport master (
    output in,
    output ld,
    output inc,
    output skip,
    output oe1,
    output oe2,
    input  out1,
    input  out2,
    input  skipPending
  );

  modport slave (
    input  in,
    input  ld,
    input  inc,
    input  skip,
    input  oe1,
    input  oe2,
    output out1,
    output out2,
    output skipPending
  );
endinterface

// File: rtl/program_counter.sv
// 12-bit program counter with edge-detected load/increment/skip strobes and wired-OR outputs.
// Optional macro PC_AUTOSTART_EN selects reset value 12'o0200 instead of 12'o0000.
module program_counter (
  input  logic             clk,
  input  logic             reset,
  program_counter_if.slave bus
);
  localparam int unsigned PC_W = 12;

`ifdef PC_AUTOSTART_EN
  localparam logic [PC_W-1:0] PC_RST = 12'o0200;
`else
  localparam logic [PC_W-1:0] PC_RST = 12'o0000;
`endif

  logic [PC_W-1:0] pc_q, pc_d;
  logic            skip_q, skip_d;
  logic            ld_prev_q, inc_prev_q, skip_prev_q;

  logic            ld_edge, inc_edge, skip_edge;
  logic            eff_skip;

  // Rising-edge detection against the previous clock's sample
  assign ld_edge   = bus.ld   & ~ld_prev_q;
  assign inc_edge  = bus.inc  & ~inc_prev_q;
  assign skip_edge = bus.skip & ~skip_prev_q;
  assign eff_skip  = skip_q | skip_edge;

  // Next-state: ld beats inc beats skip; a skip edge arriving with inc folds into this increment
  always_comb begin
    pc_d   = pc_q;
    skip_d = skip_q;
    if (ld_edge) begin
      pc_d   = bus.in;
      skip_d = 1'b0;
    end else if (inc_edge) begin
      pc_d   = eff_skip ? PC_W'(pc_q + PC_W'(2)) : PC_W'(pc_q + PC_W'(1));
      skip_d = 1'b0;
    end else if (skip_edge) begin
      skip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= PC_RST;
      skip_q      <= 1'b0;
      ld_prev_q   <= 1'b0;
      inc_prev_q  <= 1'b0;
      skip_prev_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      skip_q      <= skip_d;
      ld_prev_q   <= bus.ld;
      inc_prev_q  <= bus.inc;
      skip_prev_q <= bus.skip;
    end
  end

  // Wired-OR bus drivers: disabled outputs contribute zero
  always_comb begin
    bus.out1 = bus.oe1 ? pc_q : '0;
    bus.out2 = bus.oe2 ? pc_q : '0;
  end

  assign bus.skipPending = skip_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized strobes vs. a reference model.
module tb_program_counter;
`ifdef PC_AUTOSTART_EN
  localparam int RST_VAL = 'o200;
`else
  localparam int RST_VAL = 0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  // Reference model state
  int m_pc;
  bit m_armed;
  bit s_ld, s_inc, s_skip;

  program_counter_if bus ();

  program_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = RST_VAL;
    m_armed = 1'b0;
    s_ld    = 1'b0;
    s_inc   = 1'b0;
    s_skip  = 1'b0;
  endtask

  // One clock of architectural behaviour: advance = 1, or 2 when a skip is armed or arriving
  task automatic model_step(input bit l, input bit i, input bit s, input int d);
    bit rl, ri, rs;
    rl = l && !s_ld;
    ri = i && !s_inc;
    rs = s && !s_skip;
    if (rl) begin
      m_pc    = d;
      m_armed = 1'b0;
    end else if (ri) begin
      m_pc    = (m_pc + ((m_armed || rs) ? 2 : 1)) % 4096;
      m_armed = 1'b0;
    end else if (rs) begin
      m_armed = 1'b1;
    end
    s_ld   = l;
    s_inc  = i;
    s_skip = s;
  endtask

  task automatic tick(input bit l, input bit i, input bit s, input int d);
    @(negedge clk);
    bus.ld   = l;
    bus.inc  = i;
    bus.skip = s;
    bus.in   = 12'(d);
    @(posedge clk);
    if (reset) model_step(l, i, s, d);
    #1;
  endtask

  task automatic load(input int d);
    tick(1, 0, 0, d);
    tick(0, 0, 0, d);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.ld   = 1'b0;
    bus.inc  = 1'b0;
    bus.skip = 1'b0;
    bus.in   = '0;
    bus.oe1  = 1'b1;
    bus.oe2  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.out1 !== 12'(RST_VAL)) begin
      miscompares++;
      $display("FAIL reset_out1 got %o want %o", bus.out1, 12'(RST_VAL));
    end
    vectors++;
    if (bus.out2 !== 12'o0000) begin
      miscompares++;
      $display("FAIL reset_out2_disabled got %o want 0000", bus.out2);
    end
    vectors++;
    if (bus.skipPending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_skippending got %b want 0", bus.skipPending);
    end
    bus.oe2 = 1'b1;
    #1;
    vectors++;
    if (bus.out2 !== 12'(RST_VAL)) begin
      miscompares++;
      $display("FAIL reset_out2_enabled got %o want %o", bus.out2, 12'(RST_VAL));
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_inc();
    load('o1234);
    vectors++;
    if (bus.out1 !== 12'o1234) begin
      miscompares++;
      $display("FAIL load_1234 got %o want 1234", bus.out1);
    end
    tick(0, 1, 0, 0);
    vectors++;
    if (bus.out1 !== 12'o1235) begin
      miscompares++;
      $display("FAIL inc_1235 got %o want 1235", bus.out1);
    end
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    vectors++;
    if (bus.out1 !== 12'o1236 || bus.out2 !== 12'o1236) begin
      miscompares++;
      $display("FAIL inc_1236 got %o/%o want 1236", bus.out1, bus.out2);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_skip_wrap();
    load('o7776);
    tick(0, 0, 1, 0);
    vectors++;
    if (bus.skipPending !== 1'b1) begin
      miscompares++;
      $display("FAIL skip_armed got %b want 1", bus.skipPending);
    end
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    vectors++;
    if (bus.out1 !== 12'o0000 || bus.skipPending !== 1'b0) begin
      miscompares++;
      $display("FAIL skip_wrap got %o sp=%b want 0000 sp=0", bus.out1, bus.skipPending);
    end
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    vectors++;
    if (bus.out1 !== 12'o0001) begin
      miscompares++;
      $display("FAIL inc_after_skip got %o want 0001", bus.out1);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_held_inc();
    int bad;
    load('o0100);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, 1, 0, 0);
      vectors++;
      if (bus.out1 !== 12'o0101) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("FAIL held_inc clk%0d got %o want 0101", k, bus.out1);
      end
    end
    tick(0, 0, 1, 0);
    tick(1, 1, 0, 'o0500);
    vectors++;
    if (bus.out1 !== 12'o0500 || bus.skipPending !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_inc_same got %o sp=%b want 0500 sp=0", bus.out1, bus.skipPending);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    load('o7777);
    tick(0, 1, 1, 0);
    vectors++;
    if (bus.out1 !== 12'o0001 || bus.skipPending !== 1'b0) begin
      miscompares++;
      $display("FAIL skip_inc_same got %o sp=%b want 0001 sp=0", bus.out1, bus.skipPending);
    end
    tick(0, 0, 0, 0);
    load('o0010);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    vectors++;
    if (bus.out1 !== 12'o0012) begin
      miscompares++;
      $display("FAIL double_skip got %o want 0012", bus.out1);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    load('o0300);
    tick(0, 0, 1, 0);
    vectors++;
    if (bus.skipPending !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_armed got %b want 1", bus.skipPending);
    end
    @(negedge clk);
    bus.skip = 1'b0;
    bus.inc  = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (bus.skipPending !== 1'b0 || bus.out1 !== 12'(RST_VAL)) begin
      miscompares++;
      $display("FAIL async_reset got %o sp=%b want %o sp=0", bus.out1, bus.skipPending, 12'(RST_VAL));
    end
    // inc held through release must count as an edge on the first clock
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_step(0, 1, 0, 0);
    #1;
    vectors++;
    if (bus.out1 !== 12'((RST_VAL + 1) % 4096)) begin
      miscompares++;
      $display("FAIL held_through_reset got %o want %o", bus.out1, 12'((RST_VAL + 1) % 4096));
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_random();
    int bad;
    bit l, i, s;
    int d;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      l = ($urandom_range(0, 9) == 0);
      i = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = int'($urandom_range(0, 4095));
      bus.oe1 = 1'($urandom_range(0, 1));
      bus.oe2 = 1'($urandom_range(0, 1));
      tick(l, i, s, d);
      vectors++;
      if (bus.out1 !== (bus.oe1 ? 12'(m_pc) : 12'o0000) ||
          bus.out2 !== (bus.oe2 ? 12'(m_pc) : 12'o0000) ||
          bus.skipPending !== m_armed) begin
        miscompares++;
        bad++;
        if (bad < 6)
          $display("FAIL random step%0d got %o/%o sp=%b want pc=%o oe=%b%b sp=%b",
                   k, bus.out1, bus.out2, bus.skipPending, 12'(m_pc), bus.oe1, bus.oe2, m_armed);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    bus.oe1 = 1'b1;
    bus.oe2 = 1'b1;
    test_load_inc();
    test_skip_wrap();
    test_held_inc();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The module SHALL have port `clk`: input, 1 bit; single system clock; all state changes occur on its rising edge.
REQ-002 The module SHALL have port `reset`: input, 1 bit; reset is asynchronous and active-low.
REQ-003 The module SHALL have port `in`: input, 12 bits; data bus value captured on load.
REQ-004 The module SHALL have port `ld`: input, 1 bit; load strobe, rising-edge detected.
REQ-005 The module SHALL have port `inc`: input, 1 bit; increment strobe, rising-edge detected.
REQ-006 The module SHALL have port `skip`: input, 1 bit; skip-arm strobe, rising-edge detected.
REQ-007 The module SHALL have ports `oe1`, `oe2`: inputs, 1 bit each; output enables for `out1` and `out2`.
REQ-008 The module SHALL have ports `out1`, `out2`: outputs, 12 bits each; PC value when the matching enable is high, else 12'o0000 (wired-OR bus convention).
REQ-009 The module SHALL have port `skipPending`: output, 1 bit; armed-skip flag.

Function
REQ-010 The module SHALL hold a 12-bit register PC, a 1-bit skip flag, and one previous-sample register per strobe (`ld`, `inc`, `skip`).
REQ-011 An edge SHALL be detected when a strobe is sampled 1 at a rising edge of `clk` and its previous-sample register holds 0.
REQ-012 Previous-sample registers SHALL update every clock, independent of edge outcome.
REQ-013 Latency: the action SHALL take effect at the same clock edge at which its edge is detected, and be visible on enabled outputs immediately after that edge.
REQ-014 A detected `ld` edge SHALL set PC to `in` and clear the skip flag.
REQ-015 A detected `inc` edge with the effective skip clear SHALL set PC to PC+1, modulo 2^12.
REQ-016 A detected `inc` edge with the effective skip set SHALL set PC to PC+2, modulo 2^12, and clear the skip flag.
REQ-017 Effective skip SHALL equal the skip flag OR a `skip` edge detected at the same clock.
REQ-018 A detected `skip` edge without an `inc` or `ld` edge SHALL set the skip flag.
REQ-019 A `skip` edge while the flag is already set SHALL leave it set; skips SHALL NOT accumulate beyond +2.
REQ-020 Wrap-around SHALL follow modulo-2^12 arithmetic: 7777+1 = 0000; 7776+2 = 0000; 7777+2 = 0001.
REQ-021 Priority on simultaneous edges SHALL be `ld` > `inc` > `skip`.
REQ-022 A simultaneous `ld`+`inc` SHALL perform only the load, and the skip flag SHALL end cleared.
REQ-023 `out1`/`out2` SHALL be purely combinational gates of PC by `oe1`/`oe2`; both MAY be enabled at once.
REQ-024 `skipPending` SHALL be the registered skip flag, ungated.

Reset
REQ-025 `reset` low SHALL immediately (asynchronously) force PC to the reset value (see Configuration), the skip flag to 0, and all previous-sample registers to 0.
REQ-026 During reset, `out1`/`out2` SHALL still reflect the oe-gated reset value of PC.
REQ-027 A strobe held high when `reset` deasserts SHALL count as an edge at the first clock after release.
REQ-028 A reset mid-operation SHALL discard any armed skip.

Configuration
REQ-029 The module SHALL support macro PC_AUTOSTART_EN.
REQ-030 With PC_AUTOSTART_EN defined, the PC reset value SHALL be 12'o0200 (standard start address).
REQ-031 Without PC_AUTOSTART_EN, the PC reset value SHALL be 12'o0000.
REQ-032 PC_AUTOSTART_EN SHALL cause no other behavioural difference.

Verification
REQ-033 The bench SHALL cover: reset low, oe1=1 -> out1=0000 (0200 with PC_AUTOSTART_EN), out2=0000 while oe2=0, skipPending=0.
REQ-034 The bench SHALL cover: in=1234, pulse ld; then pulse inc twice -> out1 = 1234, 1235, 1236 after each detected edge.
REQ-035 The bench SHALL cover: ld 7776, pulse skip -> skipPending=1; pulse inc -> PC=0000, skipPending=0; pulse inc -> 0001.
REQ-036 The bench SHALL cover: hold inc high 10 clocks from PC=0100 -> PC=0101 only (single edge); then ld+inc rising same clock with in=0500 -> PC=0500.
REQ-037 The bench SHALL cover: skip and inc rising same clock at PC=7777 -> PC=0001, skipPending=0; two skip pulses then inc at 0010 -> 0012.
REQ-038 The bench SHALL cover: skip armed, assert reset asynchronously mid-cycle -> skipPending=0 and PC at reset value before the next clock edge.
